scan_cmd_bridge: RTL

- Consumes the quasi-static command fields loaded into the chip by the scan chain (wen, ren, addr, wdata) and executes one SIMD-engine memory/register transaction each time scan_id toggles.
- Returns read data and a completion flag into the chain's capture side (rdata, ready), to be picked up by the next scan_load_chain.
- Sits between the scan chain's chip-side registers and the engine's memory request port; it is the only clk-domain consumer of the scan chain.

---
 rtl/scan_bridge_pkg.sv | 21 ++
 rtl/scan_toggle_sync.sv | 27 ++
 rtl/scan_cmd_bridge.sv | 135 +++++++++++++
 3 files changed

// File: rtl/scan_bridge_pkg.sv
// Shared types and defaults for the scan-chain command bridge.
package scan_bridge_pkg;

    localparam int SB_ADDR_W = 16;
    localparam int SB_DATA_W = 16;
    localparam logic [SB_DATA_W-1:0] SB_ERR_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } sb_state_e;

    typedef struct packed {
        logic                 we;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/scan_toggle_sync.sv
// Brings a toggle-coded asynchronous trigger into clk and emits a one-cycle pulse per toggle.
module scan_toggle_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic toggle_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= async_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign toggle_o = s2_q ^ prev_q;

endmodule

// File: rtl/scan_cmd_bridge.sv
// Executes one engine transaction per scan_id toggle using the scanned command fields.
//   state     | meaning
//   IDLE      | waiting for a toggle; command fields captured on it
//   ISSUE     | req_valid high until accepted or timed out
//   WAIT_RESP | read accepted, waiting for resp_valid or timeout
//   DONE      | one cycle to raise static_ready, then back to IDLE
module scan_cmd_bridge
    import scan_bridge_pkg::*;
#(
    parameter int                 ADDR_W         = SB_ADDR_W,
    parameter int                 DATA_W         = SB_DATA_W,
    parameter int                 TIMEOUT_CYCLES = 16,
    parameter logic [DATA_W-1:0]  ERR_DATA       = SB_ERR_DATA
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_id_i,
    input  logic              static_wen_i,
    input  logic              static_ren_i,
    input  logic [ADDR_W-1:0] static_addr_i,
    input  logic [DATA_W-1:0] static_wdata_i,
    output logic              req_valid_o,
    output logic              req_we_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [DATA_W-1:0] req_wdata_o,
    input  logic              req_ready_i,
    input  logic              resp_valid_i,
    input  logic [DATA_W-1:0] resp_rdata_i,
    output logic [DATA_W-1:0] static_rdata_o,
    output logic              static_ready_o,
    output logic              cmd_err_o,
    output logic              cmd_drop_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic toggle;

    scan_toggle_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_i  (scan_id_i),
        .toggle_o (toggle)
    );

    sb_state_e         state_q;
    cmd_t              cmd_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic              req_valid_q;
    logic [DATA_W-1:0] static_rdata_q;
    logic              static_ready_q;
    logic              cmd_err_q;
    logic              cmd_drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cmd_q          <= '0;
            tmo_cnt_q      <= '0;
            req_valid_q    <= 1'b0;
            static_rdata_q <= '0;
            static_ready_q <= 1'b0;
            cmd_err_q      <= 1'b0;
            cmd_drop_q     <= 1'b0;
        end else begin
            // toggles outside IDLE are consumed by the synchronizer and never replayed
            if (toggle && state_q != IDLE) cmd_drop_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (toggle) begin
                        static_ready_q <= 1'b0;
                        cmd_err_q      <= 1'b0;
                        cmd_drop_q     <= 1'b0;
                        tmo_cnt_q      <= '0;
                        cmd_q          <= '{we: static_wen_i, addr: static_addr_i, wdata: static_wdata_i};
                        case ({static_wen_i, static_ren_i})
                            2'b10, 2'b01: begin
                                req_valid_q <= 1'b1;
                                state_q     <= ISSUE;
                            end
                            2'b11: begin
                                static_rdata_q <= ERR_DATA;
                                cmd_err_q      <= 1'b1;
                                state_q        <= DONE;
                            end
                            default: state_q <= DONE;
                        endcase
                    end
                end
                ISSUE: begin
                    if (req_ready_i) begin
                        req_valid_q <= 1'b0;
                        tmo_cnt_q   <= '0;
                        state_q     <= cmd_q.we ? DONE : WAIT_RESP;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        req_valid_q    <= 1'b0;
                        static_rdata_q <= ERR_DATA;
                        cmd_err_q      <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                WAIT_RESP: begin
                    if (resp_valid_i) begin
                        static_rdata_q <= resp_rdata_i;
                        state_q        <= DONE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        static_rdata_q <= ERR_DATA;
                        cmd_err_q      <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                DONE: begin
                    static_ready_q <= 1'b1;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_valid_o    = req_valid_q;
    assign req_we_o       = cmd_q.we;
    assign req_addr_o     = cmd_q.addr;
    assign req_wdata_o    = cmd_q.wdata;
    assign static_rdata_o = static_rdata_q;
    assign static_ready_o = static_ready_q;
    assign cmd_err_o      = cmd_err_q;
    assign cmd_drop_o     = cmd_drop_q;

endmodule
